id_ex: RTL and testbench
========================

# id_ex

Instruction-decode stage of the 5-stage MIPS pipeline, placed directly downstream of the instruction-fetch latch and upstream of the execute stage. It decodes the fetched instruction and holds the 32×32 register file with the write-back port. It resolves branches and jumps in ID, returning `pc_src` and target addresses to fetch, and detects load-use and branch-operand hazards to drive `stall_flag`. Decoded operands and control are registered into the ID/EX pipeline latch.

## Interface
Parameters:
- `len_data`, 32, datapath and address width
- `len_reg_addr`, 5, register-file address width (32 registers)

Ports:
- `clk` in 1: single clock, all state updates on posedge
- `reset` in 1: synchronous, active-high
- `in_instruction` in `len_data`: instruction from fetch
- `in_pc_branch` in `len_data`: PC+1 from fetch latch (word-addressed)
- `in_halt_flag_if` in 1: fetch reached end of program
- `in_wb_reg_write` in 1, `in_wb_addr` in 5, `in_wb_data` in `len_data`: write-back port
- `in_ex_mem_read` in 1, `in_ex_reg_write` in 1, `in_ex_dest` in 5: EX-stage destination info for hazards
- `in_debug_reg_addr` in 5: debug read address
- `out_pc_src` out 3: next-PC select, one-hot: 000 seq, 001 branch, 010 jump, 100 register
- `out_branch_address`, `out_pc_jump`, `out_pc_register` out `len_data`: fetch targets
- `out_stall_flag` out 1: freeze PC and fetch latch
- `out_reg_a`, `out_reg_b`, `out_imm`, `out_pc_link` out `len_data`: registered operands
- `out_rs`, `out_rt`, `out_rd` out 5; `out_shamt` out 5; `out_funct`, `out_opcode` out 6
- `out_reg_dst`, `out_alu_src`, `out_reg_write`, `out_mem_read`, `out_mem_write`, `out_mem_to_reg`, `out_link` out 1: registered control
- `out_halt_flag_id` out 1: registered halt
- `out_debug_reg_data` out `len_data`: register-file debug read

## Operation
- Supported instructions: R-type (opcode 0) plus JR (funct 001000), ADDI 001000, ANDI 001100, ORI 001101, LW 100011, SW 101011, BEQ 000100, BNE 000101, J 000010, JAL 000011, and HALT = 32'hFFFF_FFFF.
- Any other opcode decodes as a bubble, with all control signals 0.
- Register file:
  - r0 reads 0 and ignores writes.
  - Writes occur on posedge when `in_wb_reg_write` is high and the address is nonzero.
  - Reads are combinational with a write-bypass: if the read address equals `in_wb_addr` in a cycle with an active write, the read returns `in_wb_data`.
- Immediate: sign-extended `instr[15:0]`; zero-extended for ANDI and ORI.
- `out_branch_address` = `in_pc_branch` + sign-extended imm (mod 2^32).
- `out_pc_jump` = {`in_pc_branch[31:26]`, `instr[25:0]`}.
- `out_pc_register` = rs value.
- Branch resolution: BEQ/BNE compare the bypassed rs/rt values.
  - Taken branch gives pc_src 001. J/JAL give 010. JR gives 100. All else give 000.
- JAL: `out_link`=1, `out_reg_write`=1, `out_rd` forced to 31, `out_pc_link` = `in_pc_branch`.
- Hazard, `out_stall_flag`=1 when either holds:
  - (a) `in_ex_mem_read` and `in_ex_dest`≠0 and `in_ex_dest` equals rs, or equals rt for R-type/BEQ/BNE/SW.
  - (b) The current instruction is BEQ/BNE/JR, `in_ex_reg_write` is high, `in_ex_dest`≠0, and `in_ex_dest` matches a source it reads.
- During a stall:
  - `out_pc_src` is forced to 000.
  - The latch captures a bubble: all control 0, operands don't-care, latched 0.
- Halt:
  - HALT or `in_halt_flag_if` sets `out_halt_flag_id` on the next edge.
  - It is sticky until reset.
  - While set, the latch loads bubbles and `out_pc_src`=000.

## Timing
- `out_pc_src`, targets and `out_stall_flag` are combinational from the current inputs, valid in the same cycle.
- ID/EX outputs have 1-cycle latency: captured on posedge, one per cycle, no enable other than stall/halt.
- Register write to dependent read:
  - A write and a read in the same cycle are seen via bypass.
  - After the edge, the value is read from storage.
- Reset, synchronous:
  - On the first posedge with `reset`=1, all registered outputs go to 0 and all 32 registers are cleared.
  - The halt flag clears.
  - The write-back port is ignored in that cycle.
  - Combinational outputs follow `in_instruction`; fetch holds its own reset.
- Reset asserted mid-stall or mid-halt wins over both.
- A stall and a taken branch in the same cycle give stall, with pc_src 000; the branch re-resolves the next cycle.

## Configuration
- `ID_EX_DEBUG_EN` defined: `out_debug_reg_data` = register[`in_debug_reg_addr`], combinational, no bypass.
- `ID_EX_DEBUG_EN` undefined: `out_debug_reg_data` is tied to 0 and `in_debug_reg_addr` is unused. The port list is unchanged.

## Test plan
- After reset, write r5=32'h0000_0010 via WB, then ADDI r6,r5,-1 → next edge `out_reg_a`=16, `out_imm`=32'hFFFF_FFFF, `out_reg_write`=1, `out_alu_src`=1.
- Same-cycle WB r3=7 with BEQ r3,r0,+4 at `in_pc_branch`=20 → not taken, pc_src 000. With r3=0 → pc_src 001, branch address 24.
- `in_ex_mem_read`=1, `in_ex_dest`=8, instruction ADD r9,r8,r2 → stall 1, latched control all 0. Drop mem_read → stall 0, ADD latched.
- JAL target 0x40 at `in_pc_branch`=9 → pc_src 010, `out_pc_jump`=0x40, next edge `out_rd`=31, `out_pc_link`=9.
- HALT → next edge `out_halt_flag_id`=1; following ADDs latch bubbles. Then `reset` → flag 0, r1..r31 read 0.
- Write to r0 with value 5 → reads of r0 (and debug read, with `ID_EX_DEBUG_EN`) return 0.

Source files
------------

// File: rtl/id_ex.sv
// id_ex: instruction-decode stage of a 5-stage MIPS pipeline.
//
// Decodes the fetched instruction, owns the 32 x len_data register file
// (write-back port with same-cycle bypass), resolves branches/jumps in ID,
// detects load-use and branch-operand hazards, and registers operands and
// control into the ID/EX latch.
//
// Ports:
//   clk, reset                 single clock, synchronous active-high reset
//   in_instruction, in_pc_branch, in_halt_flag_if   from the fetch latch
//   in_wb_reg_write/addr/data  register-file write port
//   in_ex_mem_read/reg_write/dest   EX destination info for hazard checks
//   in_debug_reg_addr          debug read address
//   out_pc_src (one-hot), out_branch_address, out_pc_jump, out_pc_register,
//   out_stall_flag             combinational, back to fetch
//   out_reg_a/b, out_imm, out_pc_link, out_rs/rt/rd, out_shamt, out_funct,
//   out_opcode, control bits, out_halt_flag_id     registered ID/EX latch
//   out_debug_reg_data         register-file debug read
//
// Build option: define ID_EX_DEBUG_EN to enable the debug read port; when
// undefined the debug output is tied to zero.
module id_ex #(
    parameter int len_data     = 32,
    parameter int len_reg_addr = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [len_data-1:0]     in_instruction,
    input  logic [len_data-1:0]     in_pc_branch,
    input  logic                    in_halt_flag_if,
    input  logic                    in_wb_reg_write,
    input  logic [len_reg_addr-1:0] in_wb_addr,
    input  logic [len_data-1:0]     in_wb_data,
    input  logic                    in_ex_mem_read,
    input  logic                    in_ex_reg_write,
    input  logic [len_reg_addr-1:0] in_ex_dest,
    input  logic [len_reg_addr-1:0] in_debug_reg_addr,
    output logic [2:0]              out_pc_src,
    output logic [len_data-1:0]     out_branch_address,
    output logic [len_data-1:0]     out_pc_jump,
    output logic [len_data-1:0]     out_pc_register,
    output logic                    out_stall_flag,
    output logic [len_data-1:0]     out_reg_a,
    output logic [len_data-1:0]     out_reg_b,
    output logic [len_data-1:0]     out_imm,
    output logic [len_data-1:0]     out_pc_link,
    output logic [len_reg_addr-1:0] out_rs,
    output logic [len_reg_addr-1:0] out_rt,
    output logic [len_reg_addr-1:0] out_rd,
    output logic [4:0]              out_shamt,
    output logic [5:0]              out_funct,
    output logic [5:0]              out_opcode,
    output logic                    out_reg_dst,
    output logic                    out_alu_src,
    output logic                    out_reg_write,
    output logic                    out_mem_read,
    output logic                    out_mem_write,
    output logic                    out_mem_to_reg,
    output logic                    out_link,
    output logic                    out_halt_flag_id,
    output logic [len_data-1:0]     out_debug_reg_data
);

    localparam int NUM_REGS = 2 ** len_reg_addr;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [2:0] PC_SEQ = 3'b000;
    localparam logic [2:0] PC_BR  = 3'b001;
    localparam logic [2:0] PC_JMP = 3'b010;
    localparam logic [2:0] PC_REG = 3'b100;

    typedef struct packed {
        logic [len_data-1:0]     reg_a;
        logic [len_data-1:0]     reg_b;
        logic [len_data-1:0]     imm;
        logic [len_data-1:0]     pc_link;
        logic [len_reg_addr-1:0] rs;
        logic [len_reg_addr-1:0] rt;
        logic [len_reg_addr-1:0] rd;
        logic [4:0]              shamt;
        logic [5:0]              funct;
        logic [5:0]              opcode;
        logic                    reg_dst;
        logic                    alu_src;
        logic                    reg_write;
        logic                    mem_read;
        logic                    mem_write;
        logic                    mem_to_reg;
        logic                    link;
    } idex_t;

    // ---------------- register file ----------------
    logic [len_data-1:0] regs_q [NUM_REGS];
    logic [len_data-1:0] regs_d [NUM_REGS];

    always_comb begin
        regs_d = regs_q;
        if (in_wb_reg_write && in_wb_addr != '0)
            regs_d[in_wb_addr] = in_wb_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    // ---------------- decode ----------------
    logic [5:0]              opcode, funct;
    logic [len_reg_addr-1:0] rs, rt, rd;
    logic [len_data-1:0]     rs_val, rt_val, imm_sx, imm_val;
    logic                    is_rtype, is_jr, is_beq, is_bne, is_halt, reads_rt;
    logic                    c_reg_dst, c_alu_src, c_reg_write, c_mem_read;
    logic                    c_mem_write, c_mem_to_reg, c_link;
    logic                    haz_load, haz_branch, stall, taken, bubble;

    always_comb begin
        opcode   = in_instruction[31:26];
        funct    = in_instruction[5:0];
        rs       = in_instruction[25:21];
        rt       = in_instruction[20:16];
        rd       = in_instruction[15:11];
        is_rtype = (opcode == OP_RTYPE);
        is_jr    = is_rtype && (funct == FN_JR);
        is_beq   = (opcode == OP_BEQ);
        is_bne   = (opcode == OP_BNE);
        is_halt  = (in_instruction == {len_data{1'b1}});
        reads_rt = is_rtype || is_beq || is_bne || (opcode == OP_SW);

        // Reads see a same-cycle write-back; r0 is hardwired to zero.
        rs_val = regs_q[rs];
        if (rs == '0)                                      rs_val = '0;
        else if (in_wb_reg_write && in_wb_addr == rs)      rs_val = in_wb_data;
        rt_val = regs_q[rt];
        if (rt == '0)                                      rt_val = '0;
        else if (in_wb_reg_write && in_wb_addr == rt)      rt_val = in_wb_data;

        imm_sx  = {{(len_data-16){in_instruction[15]}}, in_instruction[15:0]};
        imm_val = imm_sx;
        if (opcode == OP_ANDI || opcode == OP_ORI)
            imm_val = {{(len_data-16){1'b0}}, in_instruction[15:0]};

        c_reg_dst    = 1'b0;
        c_alu_src    = 1'b0;
        c_reg_write  = 1'b0;
        c_mem_read   = 1'b0;
        c_mem_write  = 1'b0;
        c_mem_to_reg = 1'b0;
        c_link       = 1'b0;
        case (opcode)
            OP_RTYPE: if (!is_jr) begin
                c_reg_dst   = 1'b1;
                c_reg_write = 1'b1;
            end
            OP_ADDI, OP_ANDI, OP_ORI: begin
                c_alu_src   = 1'b1;
                c_reg_write = 1'b1;
            end
            OP_LW: begin
                c_alu_src    = 1'b1;
                c_reg_write  = 1'b1;
                c_mem_read   = 1'b1;
                c_mem_to_reg = 1'b1;
            end
            OP_SW: begin
                c_alu_src   = 1'b1;
                c_mem_write = 1'b1;
            end
            // JAL writes r31 through the rd path, so rd is selected.
            OP_JAL: begin
                c_reg_dst   = 1'b1;
                c_reg_write = 1'b1;
                c_link      = 1'b1;
            end
            default: ;
        endcase

        // Load-use: rs is always checked; rt only where it is a true source.
        haz_load = in_ex_mem_read && (in_ex_dest != '0) &&
                   ((in_ex_dest == rs) || (reads_rt && in_ex_dest == rt));
        // ID-resolved control flow needs its operands now, not after EX.
        haz_branch = (is_beq || is_bne || is_jr) && in_ex_reg_write &&
                     (in_ex_dest != '0) &&
                     ((in_ex_dest == rs) || ((is_beq || is_bne) && in_ex_dest == rt));
        stall  = haz_load || haz_branch;
        bubble = stall || out_halt_flag_id;

        taken = (is_beq && rs_val == rt_val) || (is_bne && rs_val != rt_val);
    end

    always_comb begin
        out_pc_src = PC_SEQ;
        if (!bubble) begin
            if (taken)                                   out_pc_src = PC_BR;
            else if (opcode == OP_J || opcode == OP_JAL) out_pc_src = PC_JMP;
            else if (is_jr)                              out_pc_src = PC_REG;
        end
    end

    assign out_branch_address = in_pc_branch + imm_sx;
    assign out_pc_jump        = {in_pc_branch[len_data-1:26], in_instruction[25:0]};
    assign out_pc_register    = rs_val;
    assign out_stall_flag     = stall;

    // ---------------- ID/EX latch ----------------
    idex_t idex_q, idex_d;
    logic  halt_q, halt_d;

    always_comb begin
        idex_d = '0;
        if (!bubble) begin
            idex_d.reg_a      = rs_val;
            idex_d.reg_b      = rt_val;
            idex_d.imm        = imm_val;
            idex_d.pc_link    = in_pc_branch;
            idex_d.rs         = rs;
            idex_d.rt         = rt;
            idex_d.rd         = (opcode == OP_JAL) ? {len_reg_addr{1'b1}} : rd;
            idex_d.shamt      = in_instruction[10:6];
            idex_d.funct      = funct;
            idex_d.opcode     = opcode;
            idex_d.reg_dst    = c_reg_dst;
            idex_d.alu_src    = c_alu_src;
            idex_d.reg_write  = c_reg_write;
            idex_d.mem_read   = c_mem_read;
            idex_d.mem_write  = c_mem_write;
            idex_d.mem_to_reg = c_mem_to_reg;
            idex_d.link       = c_link;
        end
        halt_d = halt_q || is_halt || in_halt_flag_if;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idex_q <= '0;
            halt_q <= 1'b0;
        end else begin
            idex_q <= idex_d;
            halt_q <= halt_d;
        end
    end

    assign out_reg_a        = idex_q.reg_a;
    assign out_reg_b        = idex_q.reg_b;
    assign out_imm          = idex_q.imm;
    assign out_pc_link      = idex_q.pc_link;
    assign out_rs           = idex_q.rs;
    assign out_rt           = idex_q.rt;
    assign out_rd           = idex_q.rd;
    assign out_shamt        = idex_q.shamt;
    assign out_funct        = idex_q.funct;
    assign out_opcode       = idex_q.opcode;
    assign out_reg_dst      = idex_q.reg_dst;
    assign out_alu_src      = idex_q.alu_src;
    assign out_reg_write    = idex_q.reg_write;
    assign out_mem_read     = idex_q.mem_read;
    assign out_mem_write    = idex_q.mem_write;
    assign out_mem_to_reg   = idex_q.mem_to_reg;
    assign out_link         = idex_q.link;
    assign out_halt_flag_id = halt_q;

`ifdef ID_EX_DEBUG_EN
    // Raw storage view: r0 is never written, so it reads zero here too.
    assign out_debug_reg_data = regs_q[in_debug_reg_addr];
`else
    logic unused_debug;
    assign unused_debug       = ^in_debug_reg_addr;
    assign out_debug_reg_data = '0;
`endif

endmodule

// File: tb/tb_id_ex.sv
module tb_id_ex;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr, pc, wb_data;
    logic        halt_if, wb_we, ex_mr, ex_rw;
    logic [4:0]  wb_addr, ex_dest, dbg_addr;

    logic [2:0]  out_pc_src;
    logic [31:0] out_branch_address, out_pc_jump, out_pc_register;
    logic        out_stall_flag;
    logic [31:0] out_reg_a, out_reg_b, out_imm, out_pc_link, out_debug_reg_data;
    logic [4:0]  out_rs, out_rt, out_rd, out_shamt;
    logic [5:0]  out_funct, out_opcode;
    logic        out_reg_dst, out_alu_src, out_reg_write, out_mem_read;
    logic        out_mem_write, out_mem_to_reg, out_link, out_halt_flag_id;

    int vectors = 0;
    int errs    = 0;

    always #5 clk = ~clk;

    id_ex dut (
        .clk(clk), .reset(reset),
        .in_instruction(instr), .in_pc_branch(pc), .in_halt_flag_if(halt_if),
        .in_wb_reg_write(wb_we), .in_wb_addr(wb_addr), .in_wb_data(wb_data),
        .in_ex_mem_read(ex_mr), .in_ex_reg_write(ex_rw), .in_ex_dest(ex_dest),
        .in_debug_reg_addr(dbg_addr),
        .out_pc_src(out_pc_src), .out_branch_address(out_branch_address),
        .out_pc_jump(out_pc_jump), .out_pc_register(out_pc_register),
        .out_stall_flag(out_stall_flag),
        .out_reg_a(out_reg_a), .out_reg_b(out_reg_b), .out_imm(out_imm),
        .out_pc_link(out_pc_link), .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd),
        .out_shamt(out_shamt), .out_funct(out_funct), .out_opcode(out_opcode),
        .out_reg_dst(out_reg_dst), .out_alu_src(out_alu_src),
        .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
        .out_mem_write(out_mem_write), .out_mem_to_reg(out_mem_to_reg),
        .out_link(out_link), .out_halt_flag_id(out_halt_flag_id),
        .out_debug_reg_data(out_debug_reg_data)
    );

    logic [131:0] act_comb;
    logic [167:0] act_lat;
    assign act_comb = {out_pc_src, out_branch_address, out_pc_jump, out_pc_register,
                       out_stall_flag, out_debug_reg_data};
    assign act_lat  = {out_reg_a, out_reg_b, out_imm, out_pc_link, out_rs, out_rt, out_rd,
                       out_shamt, out_funct, out_opcode, out_reg_dst, out_alu_src,
                       out_reg_write, out_mem_read, out_mem_write, out_mem_to_reg,
                       out_link, out_halt_flag_id};

    // ---------------- reference model ----------------
    logic [31:0]  rf [32];
    logic         halt_m;
    logic [131:0] e_comb;
    logic [167:0] e_lat;

    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input int fn);
        logic [31:0] w;
        w = {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
        return w;
    endfunction

    function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input int imm);
        logic [31:0] w;
        w = {6'(op), 5'(rs), 5'(rt), 16'(imm)};
        return w;
    endfunction

    function automatic logic [31:0] mread(input logic [4:0] a);
        if (a == 0) return 32'd0;
        if (wb_we && wb_addr == a) return wb_data;
        return rf[a];
    endfunction

    // Expected outputs for the inputs currently driven, against model state.
    task automatic model_eval();
        logic [5:0]  op, fn;
        logic [4:0]  rs, rt, rd;
        logic [31:0] va, vb, sx, imm, dbg;
        logic        jr, br2, src_rt, stall, taken, halt_n;
        logic [2:0]  pcs;
        logic [6:0]  ctl; // reg_dst alu_src reg_write mem_read mem_write mem_to_reg link
        op = instr[31:26]; fn = instr[5:0];
        rs = instr[25:21]; rt = instr[20:16]; rd = instr[15:11];
        va = mread(rs); vb = mread(rt);
        sx = {{16{instr[15]}}, instr[15:0]};
        imm = (op == 12 || op == 13) ? {16'd0, instr[15:0]} : sx;
        jr = (op == 0) && (fn == 8);
        br2 = (op == 4) || (op == 5);
        src_rt = (op == 0) || br2 || (op == 43);
        stall = (ex_mr && ex_dest != 0 && (ex_dest == rs || (src_rt && ex_dest == rt))) ||
                ((br2 || jr) && ex_rw && ex_dest != 0 && (ex_dest == rs || (br2 && ex_dest == rt)));
        taken = (op == 4 && va == vb) || (op == 5 && va != vb);
        if (stall || halt_m)           pcs = 3'b000;
        else if (taken)                pcs = 3'b001;
        else if (op == 2 || op == 3)   pcs = 3'b010;
        else if (jr)                   pcs = 3'b100;
        else                           pcs = 3'b000;
        case (op)
            0:         ctl = jr ? 7'b0000000 : 7'b1010000;
            8, 12, 13: ctl = 7'b0110000;
            35:        ctl = 7'b0111010;
            43:        ctl = 7'b0100100;
            3:         ctl = 7'b1010001;
            default:   ctl = 7'b0000000;
        endcase
        if (op == 3) rd = 5'd31;
`ifdef ID_EX_DEBUG_EN
        dbg = rf[dbg_addr];
        if (dbg_addr == 0) dbg = 32'd0;
`else
        dbg = 32'd0;
`endif
        halt_n = !reset && (halt_m || instr == 32'hFFFF_FFFF || halt_if);
        e_comb = {pcs, pc + sx, {pc[31:26], instr[25:0]}, va, stall, dbg};
        if (reset || stall || halt_m) e_lat = {167'd0, halt_n};
        else e_lat = {va, vb, imm, pc, rs, rt, rd, instr[10:6], fn, op, ctl, halt_n};
    endtask

    task automatic model_edge();
        if (reset) begin
            for (int i = 0; i < 32; i++) rf[i] = 32'd0;
            halt_m = 1'b0;
        end else begin
            if (wb_we && wb_addr != 0) rf[wb_addr] = wb_data;
            halt_m = halt_m || instr == 32'hFFFF_FFFF || halt_if;
        end
    endtask

    task automatic cyc();
        model_eval();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        reset = 0; instr = 32'd0; pc = 32'd0; halt_if = 0;
        wb_we = 0; wb_addr = 0; wb_data = 0;
        ex_mr = 0; ex_rw = 0; ex_dest = 0; dbg_addr = 0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle(); reset = 1; halt_m = 0;
        cyc(); cyc();
        vectors++;
        if (act_lat !== 168'd0) begin
            errs++; $display("FAIL reset_latch: got %h want 0", act_lat);
        end
        idle();
    endtask

    task automatic test_addi();
        idle(); wb_we = 1; wb_addr = 5; wb_data = 32'h10;
        cyc();
        idle(); instr = enc_i(8, 5, 6, 16'hFFFF);
        cyc();
        vectors++;
        if ({out_reg_a, out_imm, out_reg_write, out_alu_src} !== {32'd16, 32'hFFFF_FFFF, 1'b1, 1'b1}) begin
            errs++; $display("FAIL addi: got a=%h imm=%h rw=%b as=%b want a=10 imm=ffffffff rw=1 as=1",
                             out_reg_a, out_imm, out_reg_write, out_alu_src);
        end
    endtask

    task automatic test_branch();
        idle(); wb_we = 1; wb_addr = 3; wb_data = 32'd7;
        instr = enc_i(4, 3, 0, 4); pc = 32'd20;
        #3;
        vectors++;
        if (out_pc_src !== 3'b000) begin
            errs++; $display("FAIL beq_not_taken: got pc_src=%b want 000", out_pc_src);
        end
        cyc();
        wb_data = 32'd0;
        #3;
        vectors++;
        if ({out_pc_src, out_branch_address} !== {3'b001, 32'd24}) begin
            errs++; $display("FAIL beq_taken: got pc_src=%b addr=%0d want 001 24", out_pc_src, out_branch_address);
        end
        cyc();
    endtask

    task automatic test_stall();
        idle(); ex_mr = 1; ex_dest = 8; instr = enc_r(8, 2, 9, 32);
        #3;
        vectors++;
        if ({out_stall_flag, out_pc_src} !== 4'b1000) begin
            errs++; $display("FAIL stall_set: got stall=%b pc_src=%b want 1 000", out_stall_flag, out_pc_src);
        end
        cyc();
        vectors++;
        if (act_lat !== 168'd0) begin
            errs++; $display("FAIL stall_bubble: got %h want 0", act_lat);
        end
        ex_mr = 0;
        #3;
        vectors++;
        if (out_stall_flag !== 1'b0) begin
            errs++; $display("FAIL stall_clear: got %b want 0", out_stall_flag);
        end
        cyc();
        vectors++;
        if ({out_reg_write, out_reg_dst, out_rs, out_rt, out_rd} !== {1'b1, 1'b1, 5'd8, 5'd2, 5'd9}) begin
            errs++; $display("FAIL stall_add_latched: got rw=%b rdst=%b rs=%0d rt=%0d rd=%0d want 1 1 8 2 9",
                             out_reg_write, out_reg_dst, out_rs, out_rt, out_rd);
        end
    endtask

    task automatic test_jal();
        idle(); instr = 32'h0C00_0040; pc = 32'd9;
        #3;
        vectors++;
        if ({out_pc_src, out_pc_jump} !== {3'b010, 32'h40}) begin
            errs++; $display("FAIL jal_target: got pc_src=%b jump=%h want 010 00000040", out_pc_src, out_pc_jump);
        end
        cyc();
        vectors++;
        if ({out_rd, out_pc_link, out_link, out_reg_write} !== {5'd31, 32'd9, 1'b1, 1'b1}) begin
            errs++; $display("FAIL jal_latch: got rd=%0d link_pc=%0d link=%b rw=%b want 31 9 1 1",
                             out_rd, out_pc_link, out_link, out_reg_write);
        end
    endtask

    task automatic test_r0();
        idle(); wb_we = 1; wb_addr = 0; wb_data = 32'd5; instr = enc_r(0, 0, 0, 8);
        #3;
        vectors++;
        if ({out_pc_register, out_debug_reg_data} !== 64'd0) begin
            errs++; $display("FAIL r0_bypass: got reg=%h dbg=%h want 0 0", out_pc_register, out_debug_reg_data);
        end
        cyc();
        wb_we = 0;
        #3;
        vectors++;
        if ({out_pc_register, out_debug_reg_data} !== 64'd0) begin
            errs++; $display("FAIL r0_stored: got reg=%h dbg=%h want 0 0", out_pc_register, out_debug_reg_data);
        end
        cyc();
    endtask

    task automatic test_halt();
        for (int i = 1; i < 32; i++) begin
            idle(); wb_we = 1; wb_addr = 5'(i); wb_data = 32'(100 + i);
            cyc();
        end
        idle(); instr = 32'hFFFF_FFFF;
        cyc();
        vectors++;
        if (out_halt_flag_id !== 1'b1) begin
            errs++; $display("FAIL halt_set: got %b want 1", out_halt_flag_id);
        end
        instr = 32'h0800_0010;
        #3;
        vectors++;
        if (out_pc_src !== 3'b000) begin
            errs++; $display("FAIL halt_pc_src: got %b want 000", out_pc_src);
        end
        cyc();
        instr = enc_r(8, 2, 9, 32);
        cyc();
        vectors++;
        if (act_lat !== {167'd0, 1'b1}) begin
            errs++; $display("FAIL halt_bubble: got %h want 1", act_lat);
        end
        reset = 1;
        cyc();
        reset = 0;
        vectors++;
        if (out_halt_flag_id !== 1'b0) begin
            errs++; $display("FAIL halt_reset: got %b want 0", out_halt_flag_id);
        end
        for (int i = 1; i < 32; i++) begin
            instr = enc_r(i, i, 1, 32); dbg_addr = 5'(i);
            #3;
            vectors++;
            if ({out_pc_register, out_debug_reg_data} !== 64'd0) begin
                errs++; $display("FAIL reset_clears_r%0d: got reg=%h dbg=%h want 0 0", i, out_pc_register, out_debug_reg_data);
            end
            cyc();
        end
    endtask

    task automatic test_random();
        int ops [10] = '{0, 8, 12, 13, 35, 43, 4, 5, 2, 3};
        int fns [6]  = '{32, 34, 36, 37, 8, 42};
        for (int n = 0; n < 500; n++) begin
            int k;
            logic [31:0] w;
            idle();
            k = $urandom_range(0, 11);
            if (k < 10) begin
                w = enc_i(ops[k], $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 65535));
                if (ops[k] == 0) w = enc_r($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 31),
                                           fns[$urandom_range(0, 5)]) | {21'd0, 5'($urandom), 6'd0};
                if (ops[k] == 2 || ops[k] == 3) w[25:0] = 26'($urandom);
            end else if (k == 10) begin
                w = $urandom;
            end else begin
                w = ($urandom_range(0, 4) == 0) ? 32'hFFFF_FFFF : enc_i(4, $urandom_range(0, 3), $urandom_range(0, 3), 2);
            end
            instr = w;
            pc = $urandom;
            wb_we = $urandom_range(0, 1); wb_addr = 5'($urandom_range(0, 7)); wb_data = $urandom_range(0, 3);
            if ($urandom_range(0, 3) == 0) wb_data = $urandom;
            ex_mr = ($urandom_range(0, 3) == 0); ex_rw = $urandom_range(0, 1);
            ex_dest = 5'($urandom_range(0, 7)); dbg_addr = 5'($urandom_range(0, 7));
            halt_if = ($urandom_range(0, 120) == 0);
            reset = ($urandom_range(0, 40) == 0);
            model_eval();
            #3;
            vectors++;
            if (act_comb !== e_comb) begin
                errs++; $display("FAIL rand_comb[%0d] instr=%h: got %h want %h", n, instr, act_comb, e_comb);
            end
            cyc();
            vectors++;
            if (act_lat !== e_lat) begin
                errs++; $display("FAIL rand_latch[%0d]: got %h want %h", n, act_lat, e_lat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_branch();
        test_stall();
        test_jal();
        test_r0();
        test_halt();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
